// File: rtl/sop_sweeper_if.sv
// sop_sweeper_if: control, evaluation and truth-table row bundle
// for the loadable sum-of-products sweeper.
interface sop_sweeper_if #(
    parameter int N = 4
);
    logic                load;
    logic [(1<<N)-1:0]   mask;
    logic                start;
    logic                hold;
    logic [N-1:0]        x_in;
    logic                eval_s;
    logic                busy;
    logic [N-1:0]        vec_out;
    logic                f_out;
    logic                vec_valid;
    logic                done;
    logic [N:0]          ones_cnt;

    modport master (
        output load,
        output mask,
        output start,
        output hold,
        output x_in,
        input  eval_s,
        input  busy,
        input  vec_out,
        input  f_out,
        input  vec_valid,
        input  done,
        input  ones_cnt
    );

    modport slave (
        input  load,
        input  mask,
        input  start,
        input  hold,
        input  x_in,
        output eval_s,
        output busy,
        output vec_out,
        output f_out,
        output vec_valid,
        output done,
        output ones_cnt
    );
endinterface

// File: rtl/sop_sweeper.sv
// sop_sweeper: minterm-mask SoP evaluator with a truth-table sweep.
// Define SOP_SWEEP_GRAY_EN to sweep rows in Gray-code order.
module sop_sweeper #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    sop_sweeper_if.slave  bus
);
    localparam int W = 1 << N;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    mask_q;
    logic [N-1:0]    idx;
    logic [N-1:0]    seq;
    logic            row_bit;
    logic            take_start;
    logic            take_load;
    logic            emit;
    logic            last_row;

    logic            eval_s_q;
    logic            busy_q;
    logic [N-1:0]    vec_out_q;
    logic            f_out_q;
    logic            vec_valid_q;
    logic            done_q;
    logic [N:0]      ones_cnt_q;

`ifdef SOP_SWEEP_GRAY_EN
    assign seq = idx ^ (idx >> 1);
`else
    assign seq = idx;
`endif

    assign row_bit = mask_q[seq];

    // Next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        take_load  = 1'b0;
        emit       = 1'b0;
        last_row   = 1'b0;
        unique case (state_q)
            IDLE: begin
                take_load = bus.load;
                if (bus.start) begin
                    take_start = 1'b1;
                    state_d    = SWEEP;
                end
            end
            SWEEP: begin
                if (!bus.hold) begin
                    emit = 1'b1;
                    if (idx == {N{1'b1}}) begin
                        last_row = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mask, single-evaluation path and sweep datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q      <= '0;
            idx         <= '0;
            eval_s_q    <= 1'b0;
            busy_q      <= 1'b0;
            vec_out_q   <= '0;
            f_out_q     <= 1'b0;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ones_cnt_q  <= '0;
        end else begin
            if (take_load) begin
                mask_q <= bus.mask;
            end
            eval_s_q    <= mask_q[bus.x_in];
            vec_valid_q <= emit;
            done_q      <= last_row;
            busy_q      <= (state_d == SWEEP);
            if (take_start) begin
                idx        <= '0;
                ones_cnt_q <= '0;
            end
            if (emit) begin
                vec_out_q  <= seq;
                f_out_q    <= row_bit;
                ones_cnt_q <= ones_cnt_q + {{N{1'b0}}, row_bit};
                idx        <= idx + {{(N-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.eval_s    = eval_s_q;
    assign bus.busy      = busy_q;
    assign bus.vec_out   = vec_out_q;
    assign bus.f_out     = f_out_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.done      = done_q;
    assign bus.ones_cnt  = ones_cnt_q;
endmodule

// File: tb/tb_sop_sweeper.sv
// tb_sop_sweeper: directed checks of eval, sweep, hold, ignore
// rules and asynchronous reset for sop_sweeper with N=4.
module tb_sop_sweeper;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sop_sweeper_if #(.N(N)) bus ();

    sop_sweeper #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] exp_seq(input int r);
        logic [N-1:0] v;
        v = r[N-1:0];
`ifdef SOP_SWEEP_GRAY_EN
        v = v ^ (v >> 1);
`endif
        return v;
    endfunction

    task automatic test_reset();
        logic [N+13:0] got;
        bus.load  = 1'b0;
        bus.mask  = '0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.x_in  = '0;
        reset     = 1'b1;
        #12;
        got = {bus.eval_s, bus.busy, bus.vec_out, bus.f_out,
               bus.vec_valid, bus.done, bus.ones_cnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        step();
        reset = 1'b0;
        step();
        total++;
        if ({bus.busy, bus.vec_valid, bus.eval_s} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got=%b want=000",
                     {bus.busy, bus.vec_valid, bus.eval_s});
        end
    endtask

    task automatic test_eval();
        logic [3:0] xs [4];
        logic       ex [4];
        xs = '{4'b0011, 4'b0010, 4'b1001, 4'b1111};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.load = 1'b1;
        bus.mask = 16'h02AB;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.x_in = xs[i];
            step();
            total++;
            if (bus.eval_s !== ex[i]) begin
                bad++;
                $display("FAIL eval x=%b got=%b want=%b",
                         xs[i], bus.eval_s, ex[i]);
            end
        end
    endtask

    task automatic test_binary_sweep();
        logic [15:0] m;
        logic [N-1:0] ev;
        m = 16'h02AB;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            step();
            ev = exp_seq(r);
            total++;
            if ({bus.vec_valid, bus.vec_out, bus.f_out, bus.done,
                 bus.busy} !==
                {1'b1, ev, m[ev], r == 15, r != 15}) begin
                bad++;
                $display("FAIL sweep_row%0d got=%b want=%b", r,
                    {bus.vec_valid, bus.vec_out, bus.f_out, bus.done,
                     bus.busy},
                    {1'b1, ev, m[ev], r == 15, r != 15});
            end
        end
        total++;
        if (bus.ones_cnt !== 5'd6) begin
            bad++;
            $display("FAIL sweep_ones got=%0d want=6", bus.ones_cnt);
        end
        step();
        total++;
        if ({bus.vec_valid, bus.done, bus.ones_cnt} !== {2'b00, 5'd6}) begin
            bad++;
            $display("FAIL sweep_after got=%b want=0000110",
                     {bus.vec_valid, bus.done, bus.ones_cnt});
        end
    endtask

    task automatic test_hold();
        logic [15:0] m;
        int          r;
        int          cyc;
        int          done_cyc;
        m        = 16'h02AB;
        r        = 0;
        done_cyc = -1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            bus.hold = (cyc >= 6 && cyc <= 8);
            step();
            if (cyc >= 6 && cyc <= 8) begin
                total++;
                if ({bus.vec_valid, bus.done, bus.busy, bus.vec_out} !==
                    {3'b001, 4'd4}) begin
                    bad++;
                    $display("FAIL hold_cyc%0d got=%b want=0010100", cyc,
                        {bus.vec_valid, bus.done, bus.busy, bus.vec_out});
                end
            end else begin
                total++;
                if ({bus.vec_valid, bus.vec_out, bus.f_out} !==
                    {1'b1, exp_seq(r), m[exp_seq(r)]}) begin
                    bad++;
                    $display("FAIL hold_row%0d got=%b want=%b", r,
                        {bus.vec_valid, bus.vec_out, bus.f_out},
                        {1'b1, exp_seq(r), m[exp_seq(r)]});
                end
                r++;
            end
            if (bus.done === 1'b1) done_cyc = cyc;
        end
        bus.hold = 1'b0;
        total++;
        if (done_cyc != 19) begin
            bad++;
            $display("FAIL hold_done_cycle got=%0d want=19", done_cyc);
        end
        total++;
        if (bus.ones_cnt !== 5'd6) begin
            bad++;
            $display("FAIL hold_ones got=%0d want=6", bus.ones_cnt);
        end
        step();
    endtask

    task automatic test_ignore();
        bus.x_in  = 4'b0001;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            bus.load  = (r == 3);
            bus.start = (r == 3);
            bus.mask  = (r == 3) ? 16'h0000 : 16'h02AB;
            step();
        end
        bus.load  = 1'b0;
        bus.start = 1'b0;
        total++;
        if ({bus.done, bus.ones_cnt} !== {1'b1, 5'd6}) begin
            bad++;
            $display("FAIL ignore_result got=%b want=100110",
                     {bus.done, bus.ones_cnt});
        end
        total++;
        if (bus.eval_s !== 1'b1) begin
            bad++;
            $display("FAIL ignore_mask_eval got=%b want=1", bus.eval_s);
        end
        bus.load  = 1'b1;
        bus.start = 1'b1;
        bus.mask  = 16'hFFFF;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            step();
            total++;
            if ({bus.vec_valid, bus.f_out, bus.done} !==
                {2'b11, r == 15}) begin
                bad++;
                $display("FAIL same_cycle_row%0d got=%b want=%b", r,
                    {bus.vec_valid, bus.f_out, bus.done},
                    {2'b11, r == 15});
            end
        end
        total++;
        if (bus.ones_cnt !== 5'b10000) begin
            bad++;
            $display("FAIL same_cycle_ones got=%b want=10000",
                     bus.ones_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_sweep();
        logic [N+13:0] got;
        bus.load = 1'b1;
        bus.mask = 16'h02AB;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int r = 0; r < 6; r++) step();
        total++;
        if ({bus.vec_out, bus.ones_cnt} !== {4'd5, 5'd4}) begin
            bad++;
            $display("FAIL mid_before got=%b want=010100100",
                     {bus.vec_out, bus.ones_cnt});
        end
        #2;
        reset = 1'b1;
        #1;
        got = {bus.eval_s, bus.busy, bus.vec_out, bus.f_out,
               bus.vec_valid, bus.done, bus.ones_cnt};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want=0", got);
        end
        bus.x_in = 4'b0011;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if ({bus.eval_s, bus.busy, bus.done, bus.vec_valid} !==
                4'b0000) begin
                bad++;
                $display("FAIL mid_after%0d got=%b want=0000", c,
                    {bus.eval_s, bus.busy, bus.done, bus.vec_valid});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_eval();
        test_binary_sweep();
        test_hold();
        test_ignore();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
